imem_boot_loader: RTL and testbench
===================================

IMEM_BOOT_LOADER -- requirements
Module: imem_boot_loader

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- PC_WIDTH, 16, instruction-memory write-address width
- DATA_WIDTH, 16, instruction width
- INSTR_NUM, 15, maximum program length in words
- TIMEOUT_CYC, 1024, maximum idle cycles between accepted bytes while loading
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, clock
- rst_n, in, 1, asynchronous active-low reset
- start, in, 1, single-cycle load request
- rx_data, in, 8, byte stream data
- rx_valid, in, 1, byte valid
- rx_ready, out, 1, loader accepts byte
- imem_wr_en, out, 1, instruction-memory write strobe
- imem_wr_addr, out, PC_WIDTH, byte address of the written instruction
- imem_wr_data, out, DATA_WIDTH, instruction word
- cpu_rst_n, out, 1, active-low reset to the processor
- busy, out, 1, load in progress
- done, out, 1, load completed successfully
- err, out, 1, load failed
REQ-003 Reset is rst_n, asynchronous, active-low; clock is clk; all state updates on posedge clk.

Function
REQ-004 Byte transfer occurs only in a cycle with rx_valid=1 and rx_ready=1; rx_data is otherwise ignored.
REQ-005 Stream format: length byte N, then N words sent high byte first, then one checksum byte equal to the XOR of all 2N payload bytes.
REQ-006 States: IDLE, LEN, HI, LO, CSUM, DONE, ERR.
REQ-007 rx_ready shall be 1 exactly in LEN, HI, LO and CSUM.
REQ-008 busy shall be 1 exactly in LEN, HI, LO and CSUM.
REQ-009 done shall be 1 exactly in DONE.
REQ-010 err shall be 1 exactly in ERR.
REQ-011 IDLE/DONE/ERR with start=1 shall go to LEN; the word index and running XOR shall be cleared; cpu_rst_n shall be driven 0 from the next cycle.
REQ-012 start shall be ignored in LEN, HI, LO and CSUM.
REQ-013 LEN on transfer:
- N=0 or N>INSTR_NUM shall go to ERR.
- Otherwise N shall be stored and the state shall go to HI.
REQ-014 HI on transfer shall latch the high byte and go to LO.
REQ-015 LO on transfer shall cause a write in the following cycle.
REQ-016 That write shall assert imem_wr_en=1 for exactly one cycle, with imem_wr_data={high,low} and imem_wr_addr={index,1'b0}, zero-extended to PC_WIDTH.
REQ-017 After LO, the index shall increment; the state shall go to CSUM if the new index equals N, else to HI.
REQ-018 Each HI and LO byte shall be XORed into the running checksum.
REQ-019 CSUM on transfer: a byte equal to the running XOR shall go to DONE, otherwise to ERR.
REQ-020 cpu_rst_n shall be registered; it shall be 1 only in DONE and 0 in all other states.
REQ-021 The final imem write shall complete no later than the cycle DONE is entered.
REQ-022 The timeout counter shall clear on every accepted byte and on entry to LEN.
REQ-023 The timeout counter shall increment each busy cycle without a transfer; reaching TIMEOUT_CYC shall go to ERR.
REQ-024 imem_wr_en shall be 0 in every cycle other than the REQ-015 write cycles.
REQ-025 imem_wr_addr and imem_wr_data shall hold their last values when imem_wr_en=0.
REQ-026 ERR and DONE are held until start or reset.
REQ-027 The index width shall be sufficient to hold INSTR_NUM.
REQ-028 Index wrap-around shall not occur.

Reset
REQ-029 On rst_n=0 the state shall be IDLE, immediately and regardless of clk.
REQ-030 On rst_n=0 the following outputs shall be 0: rx_ready, imem_wr_en, busy, done, err and cpu_rst_n.
REQ-031 On rst_n=0 imem_wr_addr, imem_wr_data, index, XOR and timeout counter shall be 0.
REQ-032 Reset asserted mid-load shall abort the load with no further imem writes.
REQ-033 After reset, the block shall remain in IDLE until start.

Verification
REQ-034 Nominal: start, then bytes 02,42,07,E2,87,20 with rx_valid always 1 -> writes (addr 0x0000, 0x4207) and (addr 0x0002, 0xE287); done=1; cpu_rst_n rises one cycle after the 0x20 transfer.
REQ-035 Bad checksum: same stream ending 0x21 -> both writes occur; err=1; cpu_rst_n stays 0; rx_ready=0.
REQ-036 Bad length: length bytes 0x00 and 0x10 (INSTR_NUM=15) -> ERR after the length byte; no imem_wr_en pulses.
REQ-037 Backpressure/gaps: rx_valid toggled randomly with gaps < TIMEOUT_CYC -> identical writes and result to REQ-034.
REQ-038 Timeout and restart: stall TIMEOUT_CYC cycles after the HI byte -> err=1; then start plus the REQ-034 stream -> done=1 and writes from address 0.
REQ-039 Reset mid-load: rst_n asserted after the first LO byte -> all outputs 0 immediately; start ignored while rst_n=0; no further writes.

Source files
------------

// File: rtl/imem_boot_loader.sv
// Serial boot loader: receives a length-prefixed, XOR-checked word stream and
// writes it into instruction memory, holding the processor in reset until done.
module imem_boot_loader #(
    parameter int PC_WIDTH    = 16,
    parameter int DATA_WIDTH  = 16,
    parameter int INSTR_NUM   = 15,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  imem_wr_en,
    output logic [PC_WIDTH-1:0]   imem_wr_addr,
    output logic [DATA_WIDTH-1:0] imem_wr_data,
    output logic                  cpu_rst_n,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);
    localparam int IDX_W = $clog2(INSTR_NUM + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {S_IDLE, S_LEN, S_HI, S_LO, S_CSUM, S_DONE, S_ERR} state_t;

    state_t                r_state, w_nxt;
    logic [IDX_W-1:0]      r_idx, r_len;
    logic [7:0]            r_hi, r_xor;
    logic [TMO_W-1:0]      r_tmo;
    logic                  r_ready, r_busy, r_done, r_err, r_cpu_rst_n, r_wr_en;
    logic [PC_WIDTH-1:0]   r_wr_addr;
    logic [DATA_WIDTH-1:0] r_wr_data;

    logic             w_busy, w_xfer, w_len_ok, w_tmo_hit;
    logic [IDX_W-1:0] w_idx_inc;

    function automatic logic is_busy(input state_t s);
        return (s == S_LEN) || (s == S_HI) || (s == S_LO) || (s == S_CSUM);
    endfunction

    assign w_busy    = is_busy(r_state);
    assign w_xfer    = rx_valid & r_ready;
    assign w_len_ok  = (rx_data != 8'd0) && ({24'd0, rx_data} <= INSTR_NUM);
    assign w_idx_inc = r_idx + 1'b1;
    // Counter would reach TIMEOUT_CYC on this idle edge.
    assign w_tmo_hit = w_busy && !w_xfer && (r_tmo == TMO_W'(TIMEOUT_CYC - 1));

    always_comb begin
        w_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_ERR: if (start) w_nxt = S_LEN;
            S_LEN:  if (w_xfer) w_nxt = w_len_ok ? S_HI : S_ERR;
            S_HI:   if (w_xfer) w_nxt = S_LO;
            S_LO:   if (w_xfer) w_nxt = (w_idx_inc == r_len) ? S_CSUM : S_HI;
            S_CSUM: if (w_xfer) w_nxt = (rx_data == r_xor) ? S_DONE : S_ERR;
            default: w_nxt = S_IDLE;
        endcase
        if (w_tmo_hit) w_nxt = S_ERR;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_ready     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_cpu_rst_n <= 1'b0;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_idx       <= '0;
            r_len       <= '0;
            r_hi        <= '0;
            r_xor       <= '0;
            r_tmo       <= '0;
        end else begin
            r_state     <= w_nxt;
            r_ready     <= is_busy(w_nxt);
            r_busy      <= is_busy(w_nxt);
            r_done      <= (w_nxt == S_DONE);
            r_err       <= (w_nxt == S_ERR);
            r_cpu_rst_n <= (w_nxt == S_DONE);
            r_wr_en     <= 1'b0;
            if (start && !w_busy) begin
                r_idx <= '0;
                r_xor <= '0;
                r_tmo <= '0;
            end else if (w_xfer) begin
                r_tmo <= '0;
                case (r_state)
                    S_LEN: r_len <= rx_data[IDX_W-1:0];
                    S_HI: begin
                        r_hi  <= rx_data;
                        r_xor <= r_xor ^ rx_data;
                    end
                    S_LO: begin
                        r_xor     <= r_xor ^ rx_data;
                        r_idx     <= w_idx_inc;
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= PC_WIDTH'({r_idx, 1'b0});
                        r_wr_data <= DATA_WIDTH'({r_hi, rx_data});
                    end
                    default: ;
                endcase
            end else if (w_busy) begin
                r_tmo <= r_tmo + 1'b1;
            end
        end
    end

    assign rx_ready     = r_ready;
    assign busy         = r_busy;
    assign done         = r_done;
    assign err          = r_err;
    assign cpu_rst_n    = r_cpu_rst_n;
    assign imem_wr_en   = r_wr_en;
    assign imem_wr_addr = r_wr_addr;
    assign imem_wr_data = r_wr_data;
endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: expected imem writes are queued by the
// stimulus and consumed by an independent monitor; status is checked inline.
module tb_imem_boot_loader;
    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_ready, imem_wr_en, cpu_rst_n, busy, done, err;
    logic [15:0] imem_wr_addr, imem_wr_data;

    imem_boot_loader dut (
        .clk(clk), .rst_n(rst_n), .start(start), .rx_data(rx_data),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .imem_wr_en(imem_wr_en),
        .imem_wr_addr(imem_wr_addr), .imem_wr_data(imem_wr_data),
        .cpu_rst_n(cpu_rst_n), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [15:0] addr; logic [15:0] data; } wr_t;
    wr_t exp_q[$];
    wr_t mon_e;
    int  n_cmp = 0, n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && imem_wr_en) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: addr %h data %h, expected no write", imem_wr_addr, imem_wr_data);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wr_addr", {16'd0, imem_wr_addr}, {16'd0, mon_e.addr});
                chk("wr_data", {16'd0, imem_wr_data}, {16'd0, mon_e.data});
            end
        end
    end

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Presents one byte after 'gap' idle cycles; returns on the negedge after acceptance.
    task automatic send(input logic [7:0] b, input int gap);
        rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        for (int k = 0; k < 20 && !rx_ready; k++) @(negedge clk);
        if (!rx_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: byte %h not accepted, rx_ready 0, expected 1", b);
        end else begin
            @(negedge clk);
        end
        rx_valid = 1'b0;
    endtask

    task automatic push_nominal();
        exp_q.push_back('{16'h0000, 16'h4207});
        exp_q.push_back('{16'h0002, 16'hE287});
    endtask

    task automatic chk_status(input string name, input logic d, input logic e, input logic c, input logic r);
        chk({name, "_done"}, {31'd0, done}, {31'd0, d});
        chk({name, "_err"}, {31'd0, err}, {31'd0, e});
        chk({name, "_cpu_rst_n"}, {31'd0, cpu_rst_n}, {31'd0, c});
        chk({name, "_rx_ready"}, {31'd0, rx_ready}, {31'd0, r});
        chk({name, "_busy"}, {31'd0, busy}, {31'd0, r});
    endtask

    logic [7:0] nom_b [6] = '{8'h02, 8'h42, 8'h07, 8'hE2, 8'h87, 8'h20};
    int         gaps  [6] = '{3, 0, 5, 1, 2, 7};

    initial begin
        logic [7:0] x;
        #2;
        chk_status("reset", 0, 0, 0, 0);
        chk("reset_wr_en", {31'd0, imem_wr_en}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk_status("idle_after_reset", 0, 0, 0, 0);

        // nominal stream, rx_valid continuous
        do_start();
        chk_status("len_state", 0, 0, 0, 1);
        push_nominal();
        for (int i = 0; i < 5; i++) send(nom_b[i], 0);
        chk("cpu_rst_n_before_csum", {31'd0, cpu_rst_n}, 32'd0);
        send(8'h20, 0);
        chk_status("nominal", 1, 0, 1, 0);
        chk("nominal_writes_left", exp_q.size(), 32'd0);

        // bad checksum, restarted from DONE
        do_start();
        chk("cpu_rst_n_after_start", {31'd0, cpu_rst_n}, 32'd0);
        push_nominal();
        for (int i = 0; i < 5; i++) send(nom_b[i], 0);
        send(8'h21, 0);
        chk_status("bad_csum", 0, 1, 0, 0);
        chk("bad_csum_writes_left", exp_q.size(), 32'd0);

        // bad lengths
        do_start();
        send(8'h00, 0);
        chk_status("len_zero", 0, 1, 0, 0);
        do_start();
        send(8'h10, 0);
        chk_status("len_16", 0, 1, 0, 0);
        repeat (3) @(negedge clk);
        chk_status("err_held", 0, 1, 0, 0);

        // maximum length accepted
        do_start();
        send(8'd15, 0);
        x = 8'h00;
        for (int i = 0; i < 15; i++) begin
            exp_q.push_back('{16'(2 * i), {8'(8'h10 + i), 8'(8'hC3 ^ i)}});
            send(8'(8'h10 + i), 0);
            send(8'(8'hC3 ^ i), 0);
            x = x ^ 8'(8'h10 + i) ^ 8'(8'hC3 ^ i);
        end
        send(x, 0);
        chk_status("len_15", 1, 0, 1, 0);

        // gaps between bytes
        do_start();
        push_nominal();
        for (int i = 0; i < 6; i++) send(nom_b[i], gaps[i]);
        chk_status("gaps", 1, 0, 1, 0);
        chk("gaps_writes_left", exp_q.size(), 32'd0);

        // timeout after the high byte, then restart
        do_start();
        send(8'h02, 0);
        send(8'h42, 0);
        repeat (1023) @(negedge clk);
        chk_status("tmo_minus1", 0, 0, 0, 1);
        @(negedge clk);
        chk_status("tmo_hit", 0, 1, 0, 0);
        do_start();
        push_nominal();
        for (int i = 0; i < 6; i++) send(nom_b[i], 0);
        chk_status("restart", 1, 0, 1, 0);

        // reset mid-load after the first low byte
        do_start();
        exp_q.push_back('{16'h0000, 16'h4207});
        send(8'h02, 0);
        send(8'h42, 0);
        send(8'h07, 0);
        #1 rst_n = 1'b0;
        #1;
        chk_status("midreset", 0, 0, 0, 0);
        chk("midreset_wr_en", {31'd0, imem_wr_en}, 32'd0);
        start = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'hE2;
        repeat (3) @(negedge clk);
        chk_status("start_in_reset", 0, 0, 0, 0);
        chk("reset_wr_addr", {16'd0, imem_wr_addr}, 32'd0);
        chk("reset_wr_data", {16'd0, imem_wr_data}, 32'd0);
        start = 1'b0;
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        rx_valid = 1'b0;
        chk_status("idle_after_midreset", 0, 0, 0, 0);
        chk("final_writes_left", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
